clk_rst_sequencer: RTL and testbench
====================================

Name: clk_rst_sequencer

Overview:
Power-up and recovery sequencer for the clock/reset infrastructure of the AD wavelet-filter datapath. It drives the PLL reset, qualifies PLL lock through a settle window, then gates the derived clocks on. It releases the downstream resets in a fixed order: ADC capture, then filter core, then output stage. It retries failed lock attempts, reacts to lock loss, and reports status to the control logic.

Parameters:
CNT_W, 16, width of the shared cycle counter; every cycle-count parameter must be ≤ 2^CNT_W-1.
PLL_RST_CYC, 10, cycles pll_areset is held high per attempt (≥1).
LOCK_TIMEOUT, 1000, cycles allowed in WAIT_LOCK before an attempt is counted as failed (≥1).
SETTLE_CYC, 50, cycles locked must stay continuously high before clocks are enabled (≥1).
STAGE_GAP, 4, cycles between successive reset releases (≥1).
MAX_RETRY, 3, failed attempts allowed before FAULT (≥1).

Ports:
clk  in  1  reference clock (the PLL input clock); sole clock of this block.
reset  in  1  synchronous, active-high reset.
start  in  1  level enable; high runs the sequence, low forces an orderly shutdown.
pll_locked  in  1  asynchronous PLL lock flag; resynchronised internally by 2 flops (locked_s).
pll_areset  out  1  PLL reset, active-high.
clk_en  out  1  gate enable for all derived clocks.
rst_adc  out  1  ADC-capture domain reset, active-high.
rst_filt  out  1  filter-core domain reset, active-high.
rst_out  out  1  output-stage domain reset, active-high.
ready  out  1  high only in RUN.
fault  out  1  high only in FAULT.
retry_cnt  out  2  failed attempts in the current sequence; saturates at 3.
state_o  out  3  current state encoding.

Behaviour:
- Output timing: all outputs are registered and change on the same edge the state is entered.
- Reset and IDLE values: pll_areset=1, clk_en=0, rst_adc=rst_filt=rst_out=1, ready=0, fault=0, retry_cnt=0, state_o=IDLE, counter=0, sync flops=0.
- State encodings: IDLE=0, PLL_RST=1, WAIT_LOCK=2, SETTLE=3, REL_ADC=4, REL_FILT=5, RUN=6, FAULT=7.
- Counter: clears on every state entry and increments each cycle in a state. Each "after N cycles" transition fires on the edge where counter==N-1.
- IDLE: outputs as reset. Goes to PLL_RST when start=1.
- PLL_RST: pll_areset=1, others as IDLE. Goes to WAIT_LOCK after PLL_RST_CYC cycles.
- WAIT_LOCK: pll_areset=0.
  - locked_s=1 → SETTLE.
  - Otherwise, after LOCK_TIMEOUT cycles: retry_cnt+1. If the new value ≥ MAX_RETRY → FAULT, else → PLL_RST.
- SETTLE: resets still asserted.
  - locked_s=0 at any cycle → count as a failed attempt, using the same retry rule as WAIT_LOCK.
  - After SETTLE_CYC cycles with lock held → REL_ADC.
- REL_ADC: clk_en=1, rst_adc=0. After STAGE_GAP cycles → REL_FILT.
- REL_FILT: rst_filt=0 (rst_adc stays 0). After STAGE_GAP cycles → RUN.
- RUN: rst_out=0, ready=1, retry_cnt cleared to 0. Lock loss is handled per the optional feature.
- FAULT: all resets=1, pll_areset=1, clk_en=0, fault=1; retry_cnt holds its value. Exits only on reset, or on a start rising edge (start low for ≥1 cycle, then high) → PLL_RST with retry_cnt=0.
- start=0 in any state except IDLE/FAULT: next edge → IDLE; all resets assert together and clk_en=0. start=0 has priority over every other transition.
- Lock loss in REL_ADC or REL_FILT (locked_s=0): resets reassert immediately and clk_en=0; counts as a failed attempt, same retry rule.
- Simultaneous events: a timeout and lock rising on the same cycle resolve to lock (→ SETTLE).
- Nominal latency with defaults and lock already high: start sampled at edge k → PLL_RST k+1, WAIT_LOCK k+11, SETTLE k+12, REL_ADC k+62, REL_FILT k+66, RUN (ready=1) k+70.

Optional Feature:
LOCK_LOSS_RECOVER_EN
- Defined: locked_s=0 in RUN → PLL_RST on the next edge with all resets asserted and clk_en=0. retry_cnt is not incremented; the sequence runs again automatically.
- Undefined: locked_s=0 in RUN → FAULT.

Test Plan:
1. Defaults, pll_locked=1 throughout, reset released, start=1 at edge 0 → pll_areset high over edges 1–10; rst_adc falls at 62, rst_filt at 66, rst_out and ready rise at 70.
2. pll_locked=0 permanently → three timeouts of 1000 cycles each → retry_cnt reaches 3 and the state enters FAULT with fault=1 and all resets=1. Toggling start 0→1 re-enters PLL_RST with retry_cnt=0.
3. pll_locked drops for 1 cycle at SETTLE cycle 30 → retry_cnt=1, back to PLL_RST. Second attempt succeeds → RUN, retry_cnt=0.
4. In RUN, pll_locked=0 → without the macro: FAULT 3 cycles later (2 sync + 1). With LOCK_LOSS_RECOVER_EN: PLL_RST 3 cycles later, then RUN again.
5. start=0 during REL_FILT → next edge IDLE, all resets=1, clk_en=0. start=1 again → full sequence restarts.
6. reset=1 asserted mid-RUN for 1 cycle → every output at its reset value on the next edge. start still high → PLL_RST the following edge.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// Clock/reset power-up sequencer: PLL reset, lock qualification, clock gating and ordered domain reset release.
// Optional macro LOCK_LOSS_RECOVER_EN: lock loss in RUN restarts the sequence instead of entering FAULT.
module clk_rst_sequencer #(
  parameter int CNT_W        = 16,
  parameter int PLL_RST_CYC  = 10,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int SETTLE_CYC   = 50,
  parameter int STAGE_GAP    = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pll_locked,
  output logic       pll_areset,
  output logic       clk_en,
  output logic       rst_adc,
  output logic       rst_filt,
  output logic       rst_out,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    REL_ADC   = 3'd4,
    REL_FILT  = 3'd5,
    RUN       = 3'd6,
    FAULT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             locked_meta_q, locked_s_q;
  logic             start_prev_q;

  logic             pll_areset_q, pll_areset_d;
  logic             clk_en_q, clk_en_d;
  logic             rst_adc_q, rst_adc_d;
  logic             rst_filt_q, rst_filt_d;
  logic             rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  logic             attempt_fail;
  logic [1:0]       retry_inc;
  logic             retry_exhausted;

  assign retry_inc       = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
  assign retry_exhausted = ({30'd0, retry_inc} >= MAX_RETRY);

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = PLL_RST;
      end
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock wins over a timeout landing on the same cycle
        if (locked_s_q) state_d = SETTLE;
        else if (cnt_q == LOCK_LAST) attempt_fail = 1'b1;
      end
      SETTLE: begin
        if (!locked_s_q) attempt_fail = 1'b1;
        else if (cnt_q == SETTLE_LAST) state_d = REL_ADC;
      end
      REL_ADC: begin
        if (!locked_s_q) attempt_fail = 1'b1;
        else if (cnt_q == GAP_LAST) state_d = REL_FILT;
      end
      REL_FILT: begin
        if (!locked_s_q) attempt_fail = 1'b1;
        else if (cnt_q == GAP_LAST) state_d = RUN;
      end
      RUN: begin
`ifdef LOCK_LOSS_RECOVER_EN
        if (!locked_s_q) state_d = PLL_RST;
`else
        if (!locked_s_q) state_d = FAULT;
`endif
      end
      FAULT: begin
        if (start && !start_prev_q) begin
          state_d = PLL_RST;
          retry_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (attempt_fail) begin
      retry_d = retry_inc;
      state_d = retry_exhausted ? FAULT : PLL_RST;
    end

    // Orderly shutdown overrides everything outside IDLE and FAULT
    if (!start && (state_q != IDLE) && (state_q != FAULT)) state_d = IDLE;

    if ((state_d == IDLE) || (state_d == RUN)) retry_d = 2'd0;
  end

  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they register on the entry edge
  always_comb begin
    pll_areset_d = 1'b1;
    clk_en_d     = 1'b0;
    rst_adc_d    = 1'b1;
    rst_filt_d   = 1'b1;
    rst_out_d    = 1'b1;
    ready_d      = 1'b0;
    fault_d      = 1'b0;

    case (state_d)
      WAIT_LOCK, SETTLE: begin
        pll_areset_d = 1'b0;
      end
      REL_ADC: begin
        pll_areset_d = 1'b0;
        clk_en_d     = 1'b1;
        rst_adc_d    = 1'b0;
      end
      REL_FILT: begin
        pll_areset_d = 1'b0;
        clk_en_d     = 1'b1;
        rst_adc_d    = 1'b0;
        rst_filt_d   = 1'b0;
      end
      RUN: begin
        pll_areset_d = 1'b0;
        clk_en_d     = 1'b1;
        rst_adc_d    = 1'b0;
        rst_filt_d   = 1'b0;
        rst_out_d    = 1'b0;
        ready_d      = 1'b1;
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        pll_areset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      retry_q       <= 2'd0;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      pll_areset_q  <= 1'b1;
      clk_en_q      <= 1'b0;
      rst_adc_q     <= 1'b1;
      rst_filt_q    <= 1'b1;
      rst_out_q     <= 1'b1;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      locked_meta_q <= pll_locked;
      locked_s_q    <= locked_meta_q;
      start_prev_q  <= start;
      pll_areset_q  <= pll_areset_d;
      clk_en_q      <= clk_en_d;
      rst_adc_q     <= rst_adc_d;
      rst_filt_q    <= rst_filt_d;
      rst_out_q     <= rst_out_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign pll_areset = pll_areset_q;
  assign clk_en     = clk_en_q;
  assign rst_adc    = rst_adc_q;
  assign rst_filt   = rst_filt_q;
  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench for clk_rst_sequencer: expected state entries (edge, state, outputs, retry) are queued by the
// stimulus and checked by a monitor whenever any DUT output changes. Honours LOCK_LOSS_RECOVER_EN.
module tb_clk_rst_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRST  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SET   = 3'd3;
  localparam logic [2:0] S_ADC   = 3'd4;
  localparam logic [2:0] S_FILT  = 3'd5;
  localparam logic [2:0] S_RUN   = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;

  typedef struct {
    int         edgeNo;
    logic [2:0] st;
    logic [6:0] outs;
    logic [1:0] retry;
  } exp_t;

  exp_t expQ[$];
  int   vectorCnt = 0;
  int   miscompareCnt = 0;
  int   edgeCnt = 0;

  logic       clk = 1'b0;
  logic       reset, start, pll_locked;
  logic       pll_areset, clk_en, rst_adc, rst_filt, rst_out, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;
  logic [11:0] lastVec;

  clk_rst_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pll_locked (pll_locked),
    .pll_areset (pll_areset),
    .clk_en     (clk_en),
    .rst_adc    (rst_adc),
    .rst_filt   (rst_filt),
    .rst_out    (rst_out),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edgeCnt = edgeCnt + 1;

  // {pll_areset, clk_en, rst_adc, rst_filt, rst_out, ready, fault} for each state
  function automatic logic [6:0] stateOuts(input logic [2:0] s);
    case (s)
      S_WAIT, S_SET: return 7'b0_0_111_00;
      S_ADC:         return 7'b0_1_011_00;
      S_FILT:        return 7'b0_1_001_00;
      S_RUN:         return 7'b0_1_000_10;
      S_FAULT:       return 7'b1_0_111_01;
      default:       return 7'b1_0_111_00;
    endcase
  endfunction

  task automatic pushExp(input int e, input logic [2:0] s, input logic [1:0] r);
    exp_t x;
    x.edgeNo = e;
    x.st     = s;
    x.outs   = stateOuts(s);
    x.retry  = r;
    expQ.push_back(x);
  endtask

  // Standard lock-held sequence when start is first sampled at edge b+1
  task automatic pushNominal(input int b);
    pushExp(b + 1,  S_PRST, 2'd0);
    pushExp(b + 11, S_WAIT, 2'd0);
    pushExp(b + 12, S_SET,  2'd0);
    pushExp(b + 62, S_ADC,  2'd0);
    pushExp(b + 66, S_FILT, 2'd0);
    pushExp(b + 70, S_RUN,  2'd0);
  endtask

  task automatic applyStimulus(input logic s, input logic lk, input logic r);
    start      = s;
    pll_locked = lk;
    reset      = r;
  endtask

  task automatic waitEdge(input int e);
    while (edgeCnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput();
    exp_t       x;
    logic [6:0] act;
    act = {pll_areset, clk_en, rst_adc, rst_filt, rst_out, ready, fault};
    vectorCnt++;
    if (expQ.size() == 0) begin
      miscompareCnt++;
      $display("[TB] FAIL unexpected_change edge %0d: state=%0d outs=%b retry=%0d, no change expected",
               edgeCnt, state_o, act, retry_cnt);
    end else begin
      x = expQ.pop_front();
      if (x.edgeNo != edgeCnt || state_o !== x.st || act !== x.outs || retry_cnt !== x.retry) begin
        miscompareCnt++;
        $display("[TB] FAIL transition got edge=%0d state=%0d outs=%b retry=%0d, expected edge=%0d state=%0d outs=%b retry=%0d",
                 edgeCnt, state_o, act, retry_cnt, x.edgeNo, x.st, x.outs, x.retry);
      end
    end
  endtask

  // Monitor: any change of the observable output vector must match the next queued entry
  always @(negedge clk) begin
    if ({state_o, retry_cnt, pll_areset, clk_en, rst_adc, rst_filt, rst_out, ready, fault} !== lastVec) begin
      lastVec = {state_o, retry_cnt, pll_areset, clk_en, rst_adc, rst_filt, rst_out, ready, fault};
      checkOutput();
    end
  end

  initial begin
    int e, f, h, j, k, l;
    lastVec = 'x;
    applyStimulus(1'b0, 1'b1, 1'b1);
    pushExp(1, S_IDLE, 2'd0);
    waitEdge(3);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Nominal power-up with lock held
    waitEdge(5);
    e = 5;
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushNominal(e);

    // One-cycle lock loss while running
    e = e + 80;
    waitEdge(e);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdge(e + 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef LOCK_LOSS_RECOVER_EN
    pushNominal(e + 2);
    f = e;
`else
    pushExp(e + 3, S_FAULT, 2'd0);
    f = e + 6;
    waitEdge(f);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdge(f + 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushNominal(f + 1);
`endif

    // Synchronous reset pulse mid-RUN, then shutdown during REL_FILT
    e = e + 80;
    waitEdge(e);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitEdge(e + 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(e + 1,  S_IDLE, 2'd0);
    pushExp(e + 2,  S_PRST, 2'd0);
    pushExp(e + 12, S_WAIT, 2'd0);
    pushExp(e + 13, S_SET,  2'd0);
    pushExp(e + 63, S_ADC,  2'd0);
    pushExp(e + 67, S_FILT, 2'd0);
    waitEdge(e + 68);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp(e + 69, S_IDLE, 2'd0);
    h = e + 71;
    waitEdge(h);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushNominal(h);

    // Permanent lock failure: three timeouts then FAULT
    j = h + 80;
    waitEdge(j);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp(j + 1, S_IDLE, 2'd0);
    waitEdge(j + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdge(j + 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushExp(j + 4,    S_PRST,  2'd0);
    pushExp(j + 14,   S_WAIT,  2'd0);
    pushExp(j + 1014, S_PRST,  2'd1);
    pushExp(j + 1024, S_WAIT,  2'd1);
    pushExp(j + 2024, S_PRST,  2'd2);
    pushExp(j + 2034, S_WAIT,  2'd2);
    pushExp(j + 3034, S_FAULT, 2'd3);

    // start toggle leaves FAULT; low start alone must not
    k = j + 3040;
    waitEdge(k);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdge(k + 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(k + 2,  S_PRST, 2'd0);
    pushExp(k + 12, S_WAIT, 2'd0);
    pushExp(k + 13, S_SET,  2'd0);

    // One-cycle lock drop at SETTLE cycle 30, second attempt succeeds
    waitEdge(k + 43);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdge(k + 44);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(k + 46,  S_PRST, 2'd1);
    pushExp(k + 56,  S_WAIT, 2'd1);
    pushExp(k + 57,  S_SET,  2'd1);
    pushExp(k + 107, S_ADC,  2'd1);
    pushExp(k + 111, S_FILT, 2'd1);
    pushExp(k + 115, S_RUN,  2'd0);

    // Lock drop during REL_ADC counts as a failed attempt
    l = k + 125;
    waitEdge(l);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp(l + 1, S_IDLE, 2'd0);
    waitEdge(l + 2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(l + 3,  S_PRST, 2'd0);
    pushExp(l + 13, S_WAIT, 2'd0);
    pushExp(l + 14, S_SET,  2'd0);
    pushExp(l + 64, S_ADC,  2'd0);
    waitEdge(l + 64);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdge(l + 65);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(l + 67,  S_PRST, 2'd1);
    pushExp(l + 77,  S_WAIT, 2'd1);
    pushExp(l + 78,  S_SET,  2'd1);
    pushExp(l + 128, S_ADC,  2'd1);
    pushExp(l + 132, S_FILT, 2'd1);
    pushExp(l + 136, S_RUN,  2'd0);

    waitEdge(l + 145);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp(l + 146, S_IDLE, 2'd0);
    waitEdge(l + 150);
    @(negedge clk);
    #1;

    while (expQ.size() != 0) begin
      exp_t x;
      x = expQ.pop_front();
      vectorCnt++;
      miscompareCnt++;
      $display("[TB] FAIL missing_transition got none, expected edge=%0d state=%0d retry=%0d",
               x.edgeNo, x.st, x.retry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, miscompareCnt);
    $finish;
  end

endmodule
